// File: rtl/gate_test_sequencer.sv
// Stimulus sequencer for a small combinational gate. It walks every input vector,
// waits a settle time, checks the gate output against a truth table and summarises.
module gate_test_sequencer #(
  parameter int                   N_IN     = 2,
  parameter logic [2**N_IN-1:0]   EXPECTED = 4'b1110,
  parameter int                   SETTLE   = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 dut_out,
  output logic [N_IN-1:0]      vec,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [N_IN:0]        err_count,
  output logic [2**N_IN-1:0]   fail_mask
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_e;

  localparam logic [N_IN-1:0] LAST_VEC   = '1;
  localparam logic [7:0]      CNT_RELOAD = 8'(SETTLE - 1);

  state_e              state_q, state_d;
  logic [N_IN-1:0]     vec_q, vec_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic [N_IN:0]       err_q, err_d;
  logic [2**N_IN-1:0]  fail_q, fail_d;

  // NOTE: every next-state variable gets a hold/default value first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    err_d   = err_q;
    fail_d  = fail_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SETTLE;
          vec_d   = '0;
          cnt_d   = CNT_RELOAD;
          busy_d  = 1'b1;
          pass_d  = 1'b0;
          err_d   = '0;
          fail_d  = '0;
        end
      end

      S_SETTLE: begin
        if (cnt_q != 8'd0) cnt_d = cnt_q - 8'd1;
        else               state_d = S_CHECK;
      end

      S_CHECK: begin
        if (dut_out != EXPECTED[vec_q]) begin
          fail_d[vec_q] = 1'b1;
          err_d         = err_q + 1'b1;
        end
        if (vec_q == LAST_VEC) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          // Uses the updated count so a miss on the final vector is included.
          pass_d  = (err_d == '0);
        end else begin
          state_d = S_SETTLE;
          vec_d   = vec_q + 1'b1;
          cnt_d   = CNT_RELOAD;
        end
      end

      S_DONE: begin
        // The edge leaving DONE is the first one at which a held start relaunches,
        // so back-to-back runs have no idle gap and results are valid only with done.
        if (start) begin
          state_d = S_SETTLE;
          vec_d   = '0;
          cnt_d   = CNT_RELOAD;
          busy_d  = 1'b1;
          pass_d  = 1'b0;
          err_d   = '0;
          fail_d  = '0;
        end else begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      fail_q  <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
    end
  end

  assign vec       = vec_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_mask = fail_q;

endmodule

// File: tb/tb_gate_test_sequencer.sv
// Directed bench for gate_test_sequencer: default instance drives a selectable gate,
// a SETTLE=1 instance is tied to an OR gate for back-to-back runs.
module tb_gate_test_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_a = 1'b0;
  logic       start_b = 1'b0;
  logic [1:0] mode = 2'd0;  // 0 = OR, 1 = AND, 2 = stuck-at-0

  logic       dut_out_a, dut_out_b;
  logic [1:0] vec_a, vec_b;
  logic       busy_a, busy_b, done_a, done_b, pass_a, pass_b;
  logic [2:0] err_a, err_b;
  logic [3:0] mask_a, mask_b;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  always_comb begin
    case (mode)
      2'd0:    dut_out_a = vec_a[1] | vec_a[0];
      2'd1:    dut_out_a = vec_a[1] & vec_a[0];
      default: dut_out_a = 1'b0;
    endcase
  end
  assign dut_out_b = vec_b[1] | vec_b[0];

  gate_test_sequencer #(.N_IN(2), .EXPECTED(4'b1110), .SETTLE(2)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .dut_out(dut_out_a),
    .vec(vec_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .err_count(err_a), .fail_mask(mask_a)
  );

  gate_test_sequencer #(.N_IN(2), .EXPECTED(4'b1110), .SETTLE(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .dut_out(dut_out_b),
    .vec(vec_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .err_count(err_b), .fail_mask(mask_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick();
    tick();
    total++;
    if ({vec_a, busy_a, done_a, pass_a, err_a, mask_a} !== 12'd0)
      $display("FAIL reset_a: got vec=%0d busy=%b done=%b pass=%b err=%0d mask=%b, want all 0",
               vec_a, busy_a, done_a, pass_a, err_a, mask_a);
    else passed++;
    total++;
    if ({vec_b, busy_b, done_b, pass_b, err_b, mask_b} !== 12'd0)
      $display("FAIL reset_b: got vec=%0d busy=%b done=%b pass=%b err=%0d mask=%b, want all 0",
               vec_b, busy_b, done_b, pass_b, err_b, mask_b);
    else passed++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_or_gate();
    logic [1:0] exp_vec;
    mode = 2'd0;
    start_a = 1'b1;
    tick();  // edge 0
    start_a = 1'b0;
    total++;
    if (busy_a !== 1'b1 || vec_a !== 2'd0)
      $display("FAIL or_start: got busy=%b vec=%0d, want busy=1 vec=0", busy_a, vec_a);
    else passed++;
    for (int e = 1; e <= 13; e++) begin
      tick();
      exp_vec = (e < 3) ? 2'd0 : (e < 6) ? 2'd1 : (e < 9) ? 2'd2 : 2'd3;
      total++;
      if (vec_a !== exp_vec || done_a !== (e == 12))
        $display("FAIL or_timeline e=%0d: got vec=%0d done=%b, want vec=%0d done=%b",
                 e, vec_a, done_a, exp_vec, (e == 12));
      else passed++;
      if (e == 5) begin
        total++;
        if (pass_a !== 1'b0) $display("FAIL or_pass_midrun: got %b, want 0", pass_a);
        else passed++;
      end
      if (e == 12) begin
        total++;
        if (pass_a !== 1'b1 || err_a !== 3'd0 || mask_a !== 4'b0000 || busy_a !== 1'b1)
          $display("FAIL or_result: got pass=%b err=%0d mask=%b busy=%b, want 1 0 0000 1",
                   pass_a, err_a, mask_a, busy_a);
        else passed++;
      end
      if (e == 13) begin
        total++;
        if (busy_a !== 1'b0 || pass_a !== 1'b1)
          $display("FAIL or_end: got busy=%b pass=%b, want busy=0 pass=1", busy_a, pass_a);
        else passed++;
      end
    end
  endtask

  task automatic test_stuck_at_0();
    int done_edge = -1;
    mode = 2'd2;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int e = 1; e <= 20 && done_edge < 0; e++) begin
      tick();
      if (done_a === 1'b1) done_edge = e;
    end
    total++;
    if (done_edge != 12 || pass_a !== 1'b0 || err_a !== 3'd3 || mask_a !== 4'b1110)
      $display("FAIL stuck0: got done_edge=%0d pass=%b err=%0d mask=%b, want 12 0 3 1110",
               done_edge, pass_a, err_a, mask_a);
    else passed++;
    tick();
    total++;
    if (busy_a !== 1'b0 || err_a !== 3'd3)
      $display("FAIL stuck0_hold: got busy=%b err=%0d, want busy=0 err=3", busy_a, err_a);
    else passed++;
  endtask

  task automatic test_and_gate();
    int done_edge = -1;
    mode = 2'd1;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    total++;
    if (err_a !== 3'd0 || mask_a !== 4'b0000)
      $display("FAIL and_clear: got err=%0d mask=%b, want 0 0000", err_a, mask_a);
    else passed++;
    for (int e = 1; e <= 20 && done_edge < 0; e++) begin
      tick();
      if (done_a === 1'b1) done_edge = e;
    end
    total++;
    if (done_edge != 12 || pass_a !== 1'b0 || err_a !== 3'd2 || mask_a !== 4'b0110)
      $display("FAIL and_gate: got done_edge=%0d pass=%b err=%0d mask=%b, want 12 0 2 0110",
               done_edge, pass_a, err_a, mask_a);
    else passed++;
    tick();
  endtask

  task automatic test_start_while_busy();
    int done_cnt = 0;
    int done_edge = -1;
    mode = 2'd0;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int e = 1; e <= 20; e++) begin
      if (e == 7) start_a = 1'b1;  // held across edge 7: vec=2, SETTLE
      tick();
      if (e == 7) begin
        start_a = 1'b0;
        total++;
        if (vec_a !== 2'd2 || busy_a !== 1'b1)
          $display("FAIL busy_start_state: got vec=%0d busy=%b, want vec=2 busy=1", vec_a, busy_a);
        else passed++;
      end
      if (done_a === 1'b1) begin
        done_cnt++;
        done_edge = e;
      end
    end
    total++;
    if (done_cnt != 1 || done_edge != 12 || pass_a !== 1'b1 || busy_a !== 1'b0)
      $display("FAIL busy_start: got done_cnt=%0d done_edge=%0d pass=%b busy=%b, want 1 12 1 0",
               done_cnt, done_edge, pass_a, busy_a);
    else passed++;
  endtask

  task automatic test_reset_midrun();
    int done_edge = -1;
    mode = 2'd0;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int e = 1; e <= 5; e++) tick();  // CHECK of vector 1 entered at edge 5
    total++;
    if (vec_a !== 2'd1 || busy_a !== 1'b1)
      $display("FAIL midrun_pre: got vec=%0d busy=%b, want vec=1 busy=1", vec_a, busy_a);
    else passed++;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({vec_a, busy_a, done_a, pass_a, err_a, mask_a} !== 12'd0)
      $display("FAIL midrun_async: got vec=%0d busy=%b done=%b pass=%b err=%0d mask=%b, want all 0",
               vec_a, busy_a, done_a, pass_a, err_a, mask_a);
    else passed++;
    tick();
    total++;
    if (done_a !== 1'b0 || busy_a !== 1'b0)
      $display("FAIL midrun_held: got done=%b busy=%b, want 0 0", done_a, busy_a);
    else passed++;
    rst_n = 1'b1;
    tick();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int e = 1; e <= 13; e++) begin
      tick();
      if (done_a === 1'b1 && done_edge < 0) done_edge = e;
    end
    total++;
    if (done_edge != 12 || pass_a !== 1'b1 || err_a !== 3'd0 || busy_a !== 1'b0)
      $display("FAIL midrun_rerun: got done_edge=%0d pass=%b err=%0d busy=%b, want 12 1 0 0",
               done_edge, pass_a, err_a, busy_a);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_vec;
    start_b = 1'b1;
    tick();  // edge 0
    for (int e = 1; e <= 18; e++) begin
      tick();
      if (e == 10) start_b = 1'b0;
      total++;
      if (done_b !== (e == 8 || e == 17))
        $display("FAIL b2b_done e=%0d: got %b, want %b", e, done_b, (e == 8 || e == 17));
      else passed++;
      if (e <= 8) begin
        exp_vec = (e < 2) ? 2'd0 : (e < 4) ? 2'd1 : (e < 6) ? 2'd2 : 2'd3;
        total++;
        if (vec_b !== exp_vec)
          $display("FAIL b2b_vec e=%0d: got %0d, want %0d", e, vec_b, exp_vec);
        else passed++;
      end
      if (e == 8 || e == 17) begin
        total++;
        if (pass_b !== 1'b1 || err_b !== 3'd0 || mask_b !== 4'b0000)
          $display("FAIL b2b_result e=%0d: got pass=%b err=%0d mask=%b, want 1 0 0000",
                   e, pass_b, err_b, mask_b);
        else passed++;
      end
      if (e == 9) begin
        total++;
        if (pass_b !== 1'b0 || busy_b !== 1'b1 || vec_b !== 2'd0)
          $display("FAIL b2b_restart: got pass=%b busy=%b vec=%0d, want 0 1 0",
                   pass_b, busy_b, vec_b);
        else passed++;
      end
      if (e == 18) begin
        total++;
        if (busy_b !== 1'b0) $display("FAIL b2b_end: got busy=%b, want 0", busy_b);
        else passed++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_or_gate();
    test_stuck_at_0();
    test_and_gate();
    test_start_while_busy();
    test_reset_midrun();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
